// File: rtl/jtag_uart_avm_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_uart_avm_bridge
//  Description : Avalon-MM master feeding UART RX bytes into the JTAG UART
//                DATA register and polling DATA for host bytes to UART TX.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_uart_avm_bridge #(
    parameter int POLL_INTERVAL = 256,
    parameter int POLL_CNT_W    = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        avm_chipselect,
    output logic        avm_address,
    output logic        avm_read_n,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CTRL_RD = 2'd1,
        S_DATA_WR = 2'd2,
        S_DATA_RD = 2'd3
    } state_t;

    localparam logic [POLL_CNT_W-1:0] c_poll_reload = POLL_CNT_W'(POLL_INTERVAL);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_hold_valid;
    logic [7:0]            r_hold_data;
    logic [15:0]           r_wspace_cnt;
    logic [POLL_CNT_W-1:0] r_poll_cnt;
    logic                  r_ravail_pending;
    logic                  r_last_rd;
    logic                  r_ctrl_wait;

    logic                  w_done;
    logic                  w_poll_zero;
    logic                  w_wr_req;
    logic                  w_rd_req;
    logic                  w_grant;
    logic                  w_cs_nxt;
    logic                  w_addr_nxt;
    logic                  w_read_n_nxt;
    logic                  w_write_n_nxt;
    logic [31:0]           w_wdata_nxt;
    logic                  w_unused_rdata;

    assign in_ready       = reset_reset_n && !r_hold_valid;
    assign w_unused_rdata = ^avm_readdata[14:8];

    always_comb begin
        w_done      = (r_state != S_IDLE) && !avm_waitrequest;
        w_poll_zero = (r_poll_cnt == '0);
        // A CONTROL re-read after WSPACE=0 waits for the poll counter to drain
        w_wr_req    = r_hold_valid &&
                      ((r_wspace_cnt != 16'd0) || !r_ctrl_wait || w_poll_zero);
        // Reading DATA pops the host FIFO, so never while a byte is still held
        w_rd_req    = !out_valid && (w_poll_zero || r_ravail_pending);
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_wr_req && (!w_rd_req || r_last_rd)) begin
                    w_state_nxt = (r_wspace_cnt == 16'd0) ? S_CTRL_RD : S_DATA_WR;
                end else if (w_rd_req) begin
                    w_state_nxt = S_DATA_RD;
                end
            end
            default: begin
                if (!avm_waitrequest) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
        w_grant       = (r_state == S_IDLE) && (w_state_nxt != S_IDLE);
        w_cs_nxt      = (w_state_nxt != S_IDLE);
        w_addr_nxt    = (w_state_nxt == S_CTRL_RD);
        w_read_n_nxt  = !((w_state_nxt == S_CTRL_RD) || (w_state_nxt == S_DATA_RD));
        w_write_n_nxt = (w_state_nxt != S_DATA_WR);
        w_wdata_nxt   = (w_state_nxt == S_DATA_WR) ? {24'd0, r_hold_data} : 32'd0;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state          <= S_IDLE;
            r_hold_valid     <= 1'b0;
            r_hold_data      <= 8'd0;
            r_wspace_cnt     <= 16'd0;
            r_poll_cnt       <= '0;
            r_ravail_pending <= 1'b0;
            r_last_rd        <= 1'b0;
            r_ctrl_wait      <= 1'b0;
            out_valid        <= 1'b0;
            out_data         <= 8'd0;
            avm_chipselect   <= 1'b0;
            avm_address      <= 1'b0;
            avm_read_n       <= 1'b1;
            avm_write_n      <= 1'b1;
            avm_writedata    <= 32'd0;
        end else begin
            r_state        <= w_state_nxt;
            avm_chipselect <= w_cs_nxt;
            avm_address    <= w_addr_nxt;
            avm_read_n     <= w_read_n_nxt;
            avm_write_n    <= w_write_n_nxt;
            avm_writedata  <= w_wdata_nxt;

            if (!w_poll_zero) begin
                r_poll_cnt <= r_poll_cnt - POLL_CNT_W'(1);
            end
            if (in_valid && in_ready) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= in_data;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_grant) begin
                r_last_rd <= (w_state_nxt == S_DATA_RD);
                if (w_state_nxt == S_CTRL_RD) begin
                    r_ctrl_wait <= 1'b0;
                end
            end

            if (w_done) begin
                case (r_state)
                    S_CTRL_RD: begin
                        r_wspace_cnt <= avm_readdata[31:16];
                        if (avm_readdata[31:16] == 16'd0) begin
                            r_poll_cnt  <= c_poll_reload;
                            r_ctrl_wait <= 1'b1;
                        end
                    end
                    S_DATA_WR: begin
                        r_hold_valid <= 1'b0;
                        if (r_wspace_cnt != 16'd0) begin
                            r_wspace_cnt <= r_wspace_cnt - 16'd1;
                        end
                    end
                    S_DATA_RD: begin
                        if (avm_readdata[15]) begin
                            out_data         <= avm_readdata[7:0];
                            out_valid        <= 1'b1;
                            r_ravail_pending <= (avm_readdata[31:16] != 16'd0);
                        end else begin
                            r_ravail_pending <= 1'b0;
                            r_poll_cnt       <= c_poll_reload;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_uart_avm_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_uart_avm_bridge
//  Description : Directed bench with a JTAG UART slave model and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_uart_avm_bridge;

    localparam int PI = 32;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        avm_chipselect;
    logic        avm_address;
    logic        avm_read_n;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    jtag_uart_avm_bridge #(
        .POLL_INTERVAL (PI),
        .POLL_CNT_W    (16)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .avm_chipselect  (avm_chipselect),
        .avm_address     (avm_address),
        .avm_read_n      (avm_read_n),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    initial begin
        forever #5 clk_clk = ~clk_clk;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          wr_stall = 0;
    logic [31:0] ctrl_word;
    logic [31:0] data_q[$];
    logic [7:0]  exp_in_q[$];
    logic [7:0]  exp_out_q[$];
    int          m_wspace = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic is_kind(input int k);
        case (k)
            0:       return avm_chipselect && !avm_read_n && !avm_address;
            1:       return avm_chipselect && !avm_read_n && avm_address;
            default: return avm_chipselect && !avm_write_n && !avm_address;
        endcase
    endfunction

    // Slave model + scoreboard: checks state at each falling edge, then
    // predicts what the coming rising edge completes.
    task automatic monitor();
        logic        p_rst = 1'b0, p_cs = 1'b0, p_wait = 1'b0, p_ov = 1'b0, p_ordy = 1'b0;
        logic [7:0]  p_od = 8'd0;
        logic [35:0] p_bus = 36'd0, cur_bus;
        int          stall_left = 0;
        int          last_empty = -100000;
        logic [31:0] rdata;
        logic        wreq;
        forever begin
            @(negedge clk_clk);
            cyc++;
            cur_bus = {avm_chipselect, avm_address, avm_read_n, avm_write_n, avm_writedata};
            chk("in_ready", in_ready, reset_reset_n && (exp_in_q.size() == 0));
            chk("out_valid", out_valid, exp_out_q.size() != 0);
            chk("rw_excl", !avm_read_n && !avm_write_n, 1'b0);
            chk("cs_match", avm_chipselect, !avm_read_n || !avm_write_n);
            chk("wdata_hi", avm_writedata[31:8], 24'd0);
            if (!p_rst)
                chk("rst_strobes", {avm_chipselect, avm_read_n, avm_write_n}, 3'b011);
            else if (p_cs && p_wait)
                chk("bus_hold", cur_bus, p_bus);
            else if (p_cs)
                chk("strobe_drop", avm_chipselect, 1'b0);
            if (p_rst && p_ov && !p_ordy)
                chk("out_hold", {out_valid, out_data}, {1'b1, p_od});

            wreq  = 1'b0;
            rdata = 32'd0;
            if (!reset_reset_n) begin
                exp_in_q.delete();
                exp_out_q.delete();
                m_wspace   = 0;
                stall_left = 0;
                last_empty = -100000;
            end else begin
                if (avm_chipselect && !p_cs && !avm_write_n)
                    stall_left = wr_stall;
                if (avm_chipselect && !p_cs && !avm_read_n && !avm_address) begin
                    chk("rd_while_out", out_valid, 1'b0);
                    chk("poll_gap", (cyc - last_empty) >= PI, 1'b1);
                end
                if (avm_chipselect) begin
                    if (!avm_write_n && stall_left > 0) begin
                        wreq = 1'b1;
                        stall_left--;
                    end else if (!avm_write_n) begin
                        if (exp_in_q.size() == 0)
                            chk("wr_extra", 1'b1, 1'b0);
                        else
                            chk("wr_data", avm_writedata, {24'd0, exp_in_q.pop_front()});
                        chk("wr_space", m_wspace != 0, 1'b1);
                        if (m_wspace > 0) m_wspace--;
                    end else if (avm_address) begin
                        rdata    = ctrl_word;
                        m_wspace = int'(ctrl_word[31:16]);
                    end else begin
                        rdata = (data_q.size() != 0) ? data_q.pop_front() : 32'd0;
                        if (rdata[15]) exp_out_q.push_back(rdata[7:0]);
                        else           last_empty = cyc + 1;
                    end
                end
                if (out_valid && out_ready && exp_out_q.size() != 0)
                    chk("out_data", out_data, exp_out_q.pop_front());
                if (in_valid && in_ready)
                    exp_in_q.push_back(in_data);
            end
            avm_waitrequest = wreq;
            avm_readdata    = rdata;
            p_rst  = reset_reset_n;
            p_cs   = avm_chipselect;
            p_wait = wreq;
            p_bus  = cur_bus;
            p_ov   = out_valid;
            p_od   = out_data;
            p_ordy = out_ready;
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #2;
    endtask

    task automatic wait_active(input int k, input int bound, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            seen = is_kind(k);
        end
        chk(name, seen, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        logic idle = !avm_chipselect;
        for (int i = 0; i < bound && !idle; i++) begin
            step();
            idle = !avm_chipselect;
        end
        chk("idle_timeout", idle, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        chk("in_accept", ok, 1'b1);
    endtask

    initial begin
        int   kinds[$];
        int   first_rd;
        int   n;
        int   t0;
        logic cap;
        logic pcs;

        reset_reset_n   = 1'b0;
        in_valid        = 1'b1;
        in_data         = 8'h41;
        out_ready       = 1'b0;
        ctrl_word       = 32'h0040_0000;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'd0;
        fork
            monitor();
        join_none

        // 1: reset holds everything quiet, first poll follows release
        repeat (4) begin
            step();
            chk("t1_rst", {in_ready, avm_chipselect, avm_read_n, avm_write_n, out_valid}, 5'b00110);
        end
        reset_reset_n = 1'b1;
        in_valid      = 1'b0;
        #1;
        chk("t1_in_ready", in_ready, 1'b1);
        wait_active(0, 2, "t1_first_rd");
        wait_idle(5);

        // 2: WSPACE fetch then DATA write
        send_byte(8'h41);
        wait_active(1, 20, "t2_ctrl_rd");
        chk("t2_ctrl_bus", {avm_address, avm_read_n, avm_write_n}, 3'b101);
        wait_active(2, 20, "t2_wr");
        chk("t2_wdata", {avm_address, avm_writedata}, {1'b0, 32'h0000_0041});
        wait_idle(5);
        chk("t2_wspace", dut.r_wspace_cnt, 16'd63);
        chk("t2_in_ready", in_ready, 1'b1);

        // 3: stalled write holds the bus for four cycles
        wr_stall = 3;
        send_byte(8'h5A);
        wait_active(2, 10, "t3_wr");
        n = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!is_kind(2)) break;
            chk("t3_hold", {avm_address, avm_read_n, avm_write_n, avm_writedata}, {3'b010, 32'h5A});
            n++;
        end
        wr_stall = 0;
        chk("t3_cycles", n, 4);
        chk("t3_wspace", dut.r_wspace_cnt, 16'd62);

        // 4: host byte with more available; no poll while TX busy
        data_q.push_back(32'h0001_8055);
        data_q.push_back(32'h0000_8066);
        wait_active(0, 80, "t4_rd");
        wait_idle(5);
        chk("t4_out", {out_valid, out_data}, {1'b1, 8'h55});
        n = 0;
        repeat (10) begin
            step();
            if (is_kind(0)) n++;
        end
        chk("t4_no_rd", n, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        wait_active(0, 4, "t4_rd_fast");
        wait_idle(5);
        chk("t4_out2", {out_valid, out_data}, {1'b1, 8'h66});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 5: empty read backs off; pending write still goes out
        wait_active(0, 4, "t5_rd");
        wait_idle(5);
        t0 = cyc;
        chk("t5_no_out", out_valid, 1'b0);
        send_byte(8'h33);
        wait_active(2, 10, "t5_wr");
        chk("t5_wdata", avm_writedata, 32'h33);
        chk("t5_wr_early", (cyc - t0) < PI, 1'b1);
        wait_idle(5);
        wait_active(0, PI + 20, "t5_rd_next");
        chk("t5_gap", (cyc - t0) >= PI, 1'b1);
        wait_idle(5);

        // 6: continuous input with polling alternates W,R,W,R
        for (int i = 0; i < 6; i++) data_q.push_back(32'h0001_8090 + i);
        out_ready = 1'b1;
        in_data   = 8'h10;
        in_valid  = 1'b1;
        first_rd  = -1;
        pcs       = avm_chipselect;
        for (int i = 0; i < 150; i++) begin
            cap = in_ready;
            step();
            if (cap) in_data = in_data + 8'd1;
            if (avm_chipselect && !pcs) begin
                kinds.push_back(!avm_write_n ? 2 : (avm_address ? 1 : 0));
                if (first_rd < 0 && kinds[kinds.size()-1] == 0) first_rd = kinds.size() - 1;
            end
            pcs = avm_chipselect;
            if (first_rd >= 0 && kinds.size() >= first_rd + 5) break;
        end
        chk("t6_seq_len", (first_rd >= 0) && (kinds.size() >= first_rd + 5), 1'b1);
        if ((first_rd >= 0) && (kinds.size() >= first_rd + 5))
            for (int j = 1; j <= 4; j++)
                chk("t6_alt", kinds[first_rd + j], (j % 2 == 1) ? 2 : 0);

        // reset during a stalled write drops strobes and the held byte
        wr_stall = 5;
        wait_idle(10);
        wait_active(2, 30, "t6_wr_stall");
        in_valid = 1'b0;
        step();
        chk("t6_stalled", {avm_chipselect, avm_write_n}, 2'b10);
        reset_reset_n = 1'b0;
        step();
        chk("t6_rst_drop", {avm_chipselect, avm_read_n, avm_write_n, in_ready}, 4'b0110);
        reset_reset_n = 1'b1;
        wr_stall      = 0;
        #1;
        chk("t6_byte_drop", in_ready, 1'b1);
        n = 0;
        repeat (10) begin
            step();
            if (is_kind(2)) n++;
        end
        chk("t6_no_wr", n, 0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
